luz_driver: RTL

Lamp-side end of the traffic-light selector interface. Takes the 3-bit `sel_luz` light code from the semaphore controller and drives the three physical lamps. Generates the flashing amber for the off mode and passes the all-on lamp test through. Supervises the code stream: an illegal code, an illegal sequence or a stuck phase latches a fault that forces flashing amber until it is cleared.

---
 rtl/luz_driver.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/luz_driver.sv
// luz_driver: drives the green/amber/red lamps from the controller light code.
// Also generates flashing amber and supervises the code stream, latching a fault on a bad code, a bad sequence or a stuck phase.
module luz_driver #(
    parameter int unsigned BLINK_HALF = 25_000_000,
    parameter int unsigned WDOG_MAX   = 1_500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sel_luz,
    input  logic       fault_clr,
    output logic       lamp_v,
    output logic       lamp_a,
    output logic       lamp_r,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned WW = (WDOG_MAX > 0) ? $clog2(WDOG_MAX + 1) : 1;

    localparam logic [2:0] VERDE    = 3'd0;
    localparam logic [2:0] AMARILLO = 3'd1;
    localparam logic [2:0] ROJO     = 3'd2;
    localparam logic [2:0] OFF_A    = 3'd3;
    localparam logic [2:0] ONALL    = 3'd4;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_CODE  = 2'b01;
    localparam logic [1:0] FC_TRANS = 2'b10;
    localparam logic [1:0] FC_WDOG  = 2'b11;

    typedef enum logic {S_RUN, S_FAULT} state_t;

    state_t        state, state_n;
    logic [2:0]    sel_q, sel_q_n;
    logic [WW-1:0] wd_cnt, wd_cnt_n;
    logic [1:0]    fault_code_n;
    logic [BW-1:0] blink_cnt;
    logic          blink_ph;
    logic          flash_cur, flash_nxt;
    logic          lamp_v_c, lamp_a_c, lamp_r_c;

    // Allowed code sequence; the target code is known to be legal here.
    function automatic logic legal_step(input logic [2:0] cur, input logic [2:0] nxt);
        logic ok;
        ok = 1'b0;
        if (nxt == cur || nxt == OFF_A || nxt == ONALL)
            ok = 1'b1;
        else if ((cur == VERDE && nxt == AMARILLO) ||
                 (cur == AMARILLO && nxt == ROJO) ||
                 (cur == ROJO && nxt == VERDE))
            ok = 1'b1;
        else if ((cur == OFF_A || cur == ONALL) && nxt == ROJO)
            ok = 1'b1;
        return ok;
    endfunction

    // State register: FSM state, accepted code, watchdog and fault flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_RUN;
            sel_q      <= OFF_A;
            wd_cnt     <= '0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
        end else begin
            state      <= state_n;
            sel_q      <= sel_q_n;
            wd_cnt     <= wd_cnt_n;
            fault      <= (state_n == S_FAULT);
            fault_code <= fault_code_n;
        end
    end

    // Next-state: supervise the code stream in RUN, wait for an acknowledged clear in FAULT.
    always_comb begin
        state_n      = state;
        sel_q_n      = sel_q;
        wd_cnt_n     = wd_cnt;
        fault_code_n = fault_code;
        case (state)
            S_RUN: begin
                if (sel_luz > ONALL) begin
                    state_n      = S_FAULT;
                    fault_code_n = FC_CODE;
                    wd_cnt_n     = '0;
                end else if (!legal_step(sel_q, sel_luz)) begin
                    state_n      = S_FAULT;
                    fault_code_n = FC_TRANS;
                    wd_cnt_n     = '0;
                end else if (sel_luz == sel_q && sel_q != OFF_A &&
                             wd_cnt == WW'(WDOG_MAX - 1)) begin
                    state_n      = S_FAULT;
                    fault_code_n = FC_WDOG;
                    wd_cnt_n     = '0;
                end else begin
                    sel_q_n  = sel_luz;
                    wd_cnt_n = (sel_luz != sel_q || sel_luz == OFF_A) ? '0 : wd_cnt + WW'(1);
                end
            end
            S_FAULT: begin
                if (fault_clr && sel_luz == OFF_A) begin
                    state_n      = S_RUN;
                    sel_q_n      = OFF_A;
                    fault_code_n = FC_NONE;
                    wd_cnt_n     = '0;
                end
            end
            default: state_n = S_RUN;
        endcase
    end

    assign flash_cur = (state == S_FAULT) || (sel_q == OFF_A);
    assign flash_nxt = (state_n == S_FAULT) || (sel_q_n == OFF_A);

    // Blink generator; a fresh entry into flashing restarts with amber lit.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
        end else if (flash_nxt && !flash_cur) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
        end else if (flash_cur) begin
            if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Lamp decode from the current state and accepted code.
    always_comb begin
        lamp_v_c = 1'b0;
        lamp_a_c = 1'b0;
        lamp_r_c = 1'b0;
        if (state == S_FAULT) begin
            lamp_a_c = blink_ph;
        end else begin
            case (sel_q)
                VERDE:    lamp_v_c = 1'b1;
                AMARILLO: lamp_a_c = 1'b1;
                ROJO:     lamp_r_c = 1'b1;
                ONALL: begin
                    lamp_v_c = 1'b1;
                    lamp_a_c = 1'b1;
                    lamp_r_c = 1'b1;
                end
                default:  lamp_a_c = blink_ph;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lamp_v <= 1'b0;
            lamp_a <= 1'b1;
            lamp_r <= 1'b0;
        end else begin
            lamp_v <= lamp_v_c;
            lamp_a <= lamp_a_c;
            lamp_r <= lamp_r_c;
        end
    end

endmodule
